// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with memory handshake
// Optional retired-instruction counter enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              eq,
    input  logic              mem_ready,
    output logic              PcWe,
    output logic              IrWe,
    output logic              WeGrf,
    output logic              WeDm,
    output logic              mem_req,
    output logic [1:0]        RegDst,
    output logic [1:0]        WhichtoReg,
    output logic              AluSrc,
    output logic [2:0]        AluOp,
    output logic              sign,
    output logic              branch,
    output logic              JType,
    output logic              jr,
    output logic [2:0]        state,
    output logic [PERF_W-1:0] perf_instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    state_t r_state;
    state_t w_next;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic w_addu, w_subu, w_jr, w_j, w_jal, w_beq, w_ori, w_lui, w_lw, w_sw;
    logic w_rtype_alu;

    logic       w_pc_we, w_ir_we, w_we_grf, w_we_dm, w_mem_req;
    logic [1:0] w_reg_dst, w_which_to_reg;
    logic       w_alu_src, w_sign, w_branch, w_jtype, w_jr_sel;
    logic [2:0] w_alu_op;

    // eq is consumed by the NPC; only the opcode/funct fields steer this FSM.
    logic w_unused;
    assign w_unused = &{1'b0, eq, instr[25:6]};

    assign w_op        = instr[31:26];
    assign w_funct     = instr[5:0];
    assign w_addu      = (w_op == 6'h00) && (w_funct == 6'h21);
    assign w_subu      = (w_op == 6'h00) && (w_funct == 6'h23);
    assign w_jr        = (w_op == 6'h00) && (w_funct == 6'h08);
    assign w_j         = (w_op == 6'h02);
    assign w_jal       = (w_op == 6'h03);
    assign w_beq       = (w_op == 6'h04);
    assign w_ori       = (w_op == 6'h0D);
    assign w_lui       = (w_op == 6'h0F);
    assign w_lw        = (w_op == 6'h23);
    assign w_sw        = (w_op == 6'h2B);
    assign w_rtype_alu = w_addu || w_subu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = S_FETCH;
        w_pc_we        = 1'b0;
        w_ir_we        = 1'b0;
        w_we_grf       = 1'b0;
        w_we_dm        = 1'b0;
        w_mem_req      = 1'b0;
        w_reg_dst      = 2'd0;
        w_which_to_reg = 2'd0;
        w_alu_src      = 1'b0;
        w_alu_op       = ALU_ADD;
        w_sign         = 1'b0;
        w_branch       = 1'b0;
        w_jtype        = 1'b0;
        w_jr_sel       = 1'b0;

        // ALU controls are set up in EXEC and held through MEM/WB so operands stay stable.
        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            if (w_subu || w_beq) w_alu_op = ALU_SUB;
            else if (w_ori)      w_alu_op = ALU_OR;
            else if (w_lui)      w_alu_op = ALU_LUI;
            w_alu_src = w_ori || w_lui || w_lw || w_sw;
            w_sign    = w_lw || w_sw || w_beq;
        end

        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                if (w_j || w_jal) begin
                    w_jtype = 1'b1;
                    w_pc_we = 1'b1;
                    if (w_jal) begin
                        w_we_grf       = 1'b1;
                        w_reg_dst      = 2'd2;
                        w_which_to_reg = 2'd2;
                    end
                end else if (w_jr) begin
                    w_jr_sel = 1'b1;
                    w_pc_we  = 1'b1;
                end else if (w_rtype_alu || w_ori || w_lui || w_lw || w_sw || w_beq) begin
                    w_next = S_EXEC;
                end else begin
                    w_pc_we = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_beq) begin
                    w_branch = 1'b1;
                    w_pc_we  = 1'b1;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_rtype_alu || w_ori || w_lui) begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                if (w_sw) begin
                    w_we_dm = mem_ready;
                    w_pc_we = mem_ready;
                    w_next  = mem_ready ? S_FETCH : S_MEM;
                end else if (w_lw) begin
                    w_next = mem_ready ? S_WB : S_MEM;
                end
            end
            S_WB: begin
                w_we_grf       = 1'b1;
                w_pc_we        = 1'b1;
                w_reg_dst      = w_rtype_alu ? 2'd1 : 2'd0;
                w_which_to_reg = w_lw ? 2'd1 : 2'd0;
            end
            default: begin
                w_alu_src = 1'b0;
                w_sign    = 1'b0;
            end
        endcase
    end

    // Reset gates every control so an in-flight memory access is cut off immediately.
    assign PcWe       = reset & w_pc_we;
    assign IrWe       = reset & w_ir_we;
    assign WeGrf      = reset & w_we_grf;
    assign WeDm       = reset & w_we_dm;
    assign mem_req    = reset & w_mem_req;
    assign RegDst     = reset ? w_reg_dst      : 2'd0;
    assign WhichtoReg = reset ? w_which_to_reg : 2'd0;
    assign AluSrc     = reset & w_alu_src;
    assign AluOp      = reset ? w_alu_op       : 3'd0;
    assign sign       = reset & w_sign;
    assign branch     = reset & w_branch;
    assign JType      = reset & w_jtype;
    assign jr         = reset & w_jr_sel;
    assign state      = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [PERF_W-1:0] r_instret;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instret <= '0;
        end else if (PcWe) begin
            r_instret <= r_instret + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    assign perf_instret = r_instret;
`else
    assign perf_instret = '0;
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle control unit that drives the control inputs of the single-cycle-style datapath (WeGrf, WeDm, RegDst, WhichtoReg, AluSrc, AluOp, sign, branch, JType, jr). It reads back instr and eq. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. It adds PC and IR write enables and a request/ready handshake toward a variable-latency data memory.

Parameters:
PERF_W, 32, width of the optional retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr  in  32  current instruction (datapath IR output)
eq  in  1  ALU equality flag
mem_ready  in  1  data memory completes the access this cycle
PcWe  out  1  PC register load enable
IrWe  out  1  IR load enable
WeGrf  out  1  register file write enable
WeDm  out  1  data memory write strobe
mem_req  out  1  data memory access request
RegDst  out  2  0=rt, 1=rd, 2=$31
WhichtoReg  out  2  0=ALU res, 1=MemRead, 2=PC4
AluSrc  out  1  0=RegRead2, 1=imm32
AluOp  out  3  0=ADD, 1=SUB, 2=OR, 3=LUI
sign  out  1  1=sign-extend imm16, 0=zero-extend
branch  out  1  NPC selects branch target when eq
JType  out  1  NPC selects imm26 jump target
jr  out  1  NPC selects RegRead1
state  out  3  current state, for debug
perf_instret  out  PERF_W  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. A 3-bit state register is the only required storage, apart from the optional counter.
- Reset asserted (reset==0): state=FETCH asynchronously. All outputs are forced to 0 while reset is low, including IrWe. After reset is released, the first rising edge runs FETCH.
- Outputs are combinational in the state and instr fields. Every control not listed for a state is 0.
- FETCH: IrWe=1. Next state is DECODE.
- DECODE:
  - j: JType=1, PcWe=1.
  - jal: JType=1, PcWe=1, WeGrf=1, RegDst=2, WhichtoReg=2.
  - jr (op 0, funct 0x08): jr=1, PcWe=1.
  - The three jumps above, and any unsupported opcode/funct, go next to FETCH. An unsupported instruction is a nop: PcWe=1, all selects 0, PC+4.
  - Other instructions go next to EXEC.
- EXEC:
  - addu (funct 0x21): AluOp=ADD. subu (funct 0x23): AluOp=SUB. Both use AluSrc=0, next state WB.
  - ori: AluOp=OR, AluSrc=1, sign=0, next state WB.
  - lui: AluOp=LUI, AluSrc=1, sign=0, next state WB.
  - lw/sw: AluOp=ADD, AluSrc=1, sign=1, next state MEM.
  - beq: AluOp=SUB, AluSrc=0, sign=1, branch=1, PcWe=1, next state FETCH. The target is resolved by the NPC from eq.
- MEM (lw/sw):
  - mem_req=1 and the ALU controls of EXEC are held, so the address stays stable.
  - The state stays in MEM until mem_ready=1 is sampled.
  - sw: WeDm=mem_ready. PcWe=mem_ready. Next state is FETCH when ready.
  - lw: next state is WB when ready. WeDm is never asserted for lw.
  - mem_ready while not in MEM is ignored.
- WB:
  - EXEC controls are held. WeGrf=1, PcWe=1.
  - R-type: RegDst=1, WhichtoReg=0. ori/lui: RegDst=0, WhichtoReg=0. lw: RegDst=0, WhichtoReg=1, mem_req=0.
  - Next state is FETCH.
- Cycle counts:
  - j/jal/jr/nop: 2.
  - beq: 3.
  - R-type/ori/lui: 4.
  - sw: 4+w. lw: 5+w. w = number of MEM cycles with mem_ready=0.
- PcWe is asserted exactly once per instruction, in its last cycle. IrWe is asserted only in FETCH.
- Reset mid-instruction (including in MEM with mem_req=1): mem_req and WeDm drop immediately and asynchronously. No partial write is issued afterwards.
- Illegal state encodings 5-7: next state is FETCH, all outputs 0.

Optional Feature:
MC_CTRL_PERF_EN
- Defined: perf_instret is a PERF_W register. It resets to 0, increments on every clock edge with PcWe=1, and wraps at 2^PERF_W-1 to 0.
- Undefined: perf_instret is tied to 0 and no counter is synthesised.

Test Plan:
- reset low for 3 cycles, then release with instr=0x00221821 (addu $3,$1,$2) -> during reset all outputs 0. Then state 0,1,2,4. In WB: WeGrf=1, RegDst=1, WhichtoReg=0, AluOp=0, PcWe=1. perf_instret=1 with macro, 0 without.
- instr=0x8C040008 (lw $4,8($0)), mem_ready low for 2 MEM cycles then high -> MEM for 3 cycles with mem_req=1, AluSrc=1, sign=1. WB: RegDst=0, WhichtoReg=1, WeGrf=1. Total 7 cycles, WeDm never 1.
- instr=0xAC04000C (sw), mem_ready=1 at first MEM cycle -> WeDm=1 and PcWe=1 in that single cycle. Back to FETCH after 4 cycles. WeGrf never 1.
- instr=0x10220002 (beq) with eq=1, then eq=0 -> each takes 3 cycles. EXEC: branch=1, PcWe=1, AluOp=1.
- instr=0x0C000003 (jal), then 0x03E00008 (jr $31), then 0x3421FFFF (ori) -> jal: DECODE has JType=1, WeGrf=1, RegDst=2, WhichtoReg=2 (2 cycles). jr: jr=1 (2 cycles). ori: sign=0, AluOp=2.
- sw stalled in MEM, then reset pulsed low -> mem_req goes 0 within the same cycle. After release: state=0 and no WeDm pulse. Opcode 0x3F -> nop, 2 cycles, PcWe=1 only.
